i2s_dac_tx: RTL and testbench
=============================

# i2s_dac_tx

I2S transmitter that serializes stereo PCM samples onto the codec DAC data line. The codec is the I2S clock master, so bit clock and DAC LR clock arrive as asynchronous inputs. They are synchronized into the 50 MHz domain and edge-detected there. It is the output-side counterpart of the ADC capture path and sits between the effect pipeline and the audio codec pins.

## Interface
Parameters:
- DATA_WIDTH, 24, bits per channel word, MSB first; legal range 16–32.
- SYNC_STAGES, 2, flip-flop stages on bclk/lrck synchronizers; minimum 2.

Ports:
- CLOCK_50  input  1  sole clock, 50 MHz; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- aud_bclk  input  1  codec bit clock, asynchronous, ≤ 12.5 MHz.
- aud_daclrck  input  1  codec DAC LR clock, asynchronous; low = left, high = right.
- left_data  input  DATA_WIDTH  left sample, two's complement.
- right_data  input  DATA_WIDTH  right sample, two's complement.
- sample_valid  input  1  producer has a stereo pair on left_data/right_data.
- sample_ready  output  1  holding register empty; a pair is accepted when valid && ready.
- aud_dacdat  output  1  serial DAC data to codec.
- frame_start  output  1  one-cycle pulse when a new pair enters transmission.
- underrun  output  1  one-cycle pulse when a left frame starts with no pair held.

## Operation
- Both aud_bclk and aud_daclrck pass through identical SYNC_STAGES synchronizers, then through one edge-detect register each.
- Edge-detect outputs:
  - bclk_fall
  - lrck_fall (left start)
  - lrck_rise (right start)
- Holding register: one stereo pair plus a hold_full flag. sample_ready = !hold_full, driven directly from the register.
- Transmit registers: tx_l and tx_r (DATA_WIDTH each), a shift register, and a bit counter (0..DATA_WIDTH).
- States:
  - IDLE: after reset. aud_dacdat held 0. lrck_rise is ignored. On lrck_fall go to LEFT.
  - LEFT: entered on lrck_fall, from IDLE or RIGHT.
    - If hold_full: copy the pair to tx_l/tx_r, clear hold_full, pulse frame_start.
    - Otherwise pulse underrun and apply the underrun policy (see Configuration).
    - Load the shift register with tx_l and clear the bit counter.
    - On lrck_rise go to RIGHT.
  - RIGHT: entered on lrck_rise. Load the shift register with tx_r and clear the bit counter. On lrck_fall go to LEFT.
- Shifting:
  - In LEFT/RIGHT, each bclk_fall with bit counter < DATA_WIDTH drives aud_dacdat = shift MSB, shifts left, and increments the counter.
  - When the counter equals DATA_WIDTH, aud_dacdat is driven 0 until the next LR edge.
  - This gives standard I2S framing: MSB appears on the first BCLK falling edge after the LR transition and is sampled by the codec on the following rising edge.
- Boundary conditions:
  - An LR edge and bclk_fall in the same cycle: the LR edge wins. The shift register reloads, aud_dacdat holds its value, and that bclk_fall does not shift.
  - An LR edge arrives before DATA_WIDTH bits are sent (short frame): the word is truncated and the new channel loads normally.
  - sample_valid while hold_full: ignored, and the producer must hold its data.
  - hold_full is cleared only at lrck_fall, and sample_ready is registered, so load and transfer never occur in the same cycle.
  - reset mid-frame: all state returns to IDLE in the next cycle. The transmission in progress is abandoned.

## Timing
- Reset values:
  - aud_dacdat = 0, sample_ready = 1, frame_start = 0, underrun = 0.
  - hold_full = 0; tx_l, tx_r and the shift register = 0; state IDLE.
- Pin-edge to detect latency: SYNC_STAGES + 1 CLOCK_50 cycles.
- bclk_fall to aud_dacdat update: 1 cycle, registered output. Total pin-to-pin latency is SYNC_STAGES + 2 cycles, which is 80 ns at the default setting. This is well inside the half period of a 3.072 MHz BCLK.
- frame_start and underrun assert in the cycle after lrck_fall is detected, for exactly one cycle.
- sample_ready falls in the cycle after an accepted handshake and rises in the cycle after the pair transfers at lrck_fall.

## Configuration
- I2S_TX_UNDERRUN_ZERO_EN:
  - Defined: on underrun, tx_l and tx_r are cleared to 0, so silence is transmitted.
  - Undefined: tx_l and tx_r keep the previous pair, so the last sample is repeated.
- underrun pulses in both builds.

## Test plan
Bench setup: aud_bclk period 16 cycles, 64 BCLKs per LRCK period, DATA_WIDTH = 24.

- Reset, then the first lrck_fall with pair L = 24'hA5A5A5, R = 24'h3C3C3C loaded before it:
  - frame_start pulses once.
  - The decoded left word is A5A5A5, starting on the first BCLK fall after the edge.
  - The right word is 3C3C3C.
  - Bits 25–32 of each half-frame are 0.
- One pair supplied per frame for 4 frames (L = 1, 2, 3, 4):
  - Decoded sequence is 1, 2, 3, 4.
  - sample_ready toggles once per frame.
  - underrun is never asserted.
- No pair supplied for frame 2 after L = 24'h123456:
  - underrun pulses once.
  - Frame 2 left word = 123456 without the macro, 000000 with I2S_TX_UNDERRUN_ZERO_EN.
- sample_valid held high with a second pair while hold_full:
  - The second pair is not accepted until after lrck_fall.
  - The decoded order is preserved.
- Short frame: LRCK toggles after 16 BCLKs with L = 24'hFFFFFF:
  - 16 ones are output, then the right word loads cleanly.
  - No stray bits appear.
- reset asserted mid-left word:
  - aud_dacdat = 0 in the next cycle.
  - Output stays 0 through the following lrck_rise.
  - Transmission resumes only at the next lrck_fall.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx -- I2S serializer for the codec DAC data line.
//
// The codec is the I2S clock master: aud_bclk and aud_daclrck arrive
// asynchronously and are synchronized into the CLOCK_50 domain, then edge
// detected. A one-pair holding register decouples the producer from the
// frame timing. Each left frame start moves the held pair into the transmit
// registers. If no pair is held, the left frame start flags an underrun.
//
// Optional build macro:
//   I2S_TX_UNDERRUN_ZERO_EN  -- on underrun transmit silence (zero words)
//                               instead of repeating the previous pair.
module i2s_dac_tx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  aud_bclk,
  input  logic                  aud_daclrck,
  input  logic [DATA_WIDTH-1:0] left_data,
  input  logic [DATA_WIDTH-1:0] right_data,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  aud_dacdat,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  // Synchronizer chains and edge-detect registers
  logic [SYNC_STAGES-1:0] bclk_sync_r;
  logic [SYNC_STAGES-1:0] lrck_sync_r;
  logic                   bclk_dly_r;
  logic                   lrck_dly_r;
  logic                   bclk_fall_r;
  logic                   lrck_fall_r;
  logic                   lrck_rise_r;

  // Control FSM
  state_t state_r;
  state_t state_nxt_s;
  logic   enter_left_s;
  logic   enter_right_s;
  logic   active_s;
  logic   shift_s;
  logic   zero_s;

  // Holding and transmit datapath
  logic                  accept_s;
  logic                  hold_full_r;
  logic [DATA_WIDTH-1:0] hold_l_r;
  logic [DATA_WIDTH-1:0] hold_r_r;
  logic [DATA_WIDTH-1:0] tx_l_r;
  logic [DATA_WIDTH-1:0] tx_r_r;
  logic [DATA_WIDTH-1:0] left_src_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic                  dacdat_r;
  logic                  frame_start_r;
  logic                  underrun_r;

  // Bring both codec clocks into the CLOCK_50 domain through identical chains
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_sync_r <= {SYNC_STAGES{1'b0}};
      lrck_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      bclk_sync_r <= {bclk_sync_r[SYNC_STAGES-2:0], aud_bclk};
      lrck_sync_r <= {lrck_sync_r[SYNC_STAGES-2:0], aud_daclrck};
    end
  end

  // Registered edge detection; bclk and lrck stay cycle-aligned with each other
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_dly_r  <= 1'b0;
      lrck_dly_r  <= 1'b0;
      bclk_fall_r <= 1'b0;
      lrck_fall_r <= 1'b0;
      lrck_rise_r <= 1'b0;
    end else begin
      bclk_dly_r  <= bclk_sync_r[SYNC_STAGES-1];
      lrck_dly_r  <= lrck_sync_r[SYNC_STAGES-1];
      bclk_fall_r <= bclk_dly_r & ~bclk_sync_r[SYNC_STAGES-1];
      lrck_fall_r <= lrck_dly_r & ~lrck_sync_r[SYNC_STAGES-1];
      lrck_rise_r <= ~lrck_dly_r & lrck_sync_r[SYNC_STAGES-1];
    end
  end

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: a left start always wins, a right start only counts once framed
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (lrck_fall_r) state_nxt_s = ST_LEFT;
        else             state_nxt_s = ST_IDLE;
      end
      ST_LEFT: begin
        if (lrck_rise_r)      state_nxt_s = ST_RIGHT;
        else if (lrck_fall_r) state_nxt_s = ST_LEFT;
        else                  state_nxt_s = ST_LEFT;
      end
      ST_RIGHT: begin
        if (lrck_fall_r) state_nxt_s = ST_LEFT;
        else             state_nxt_s = ST_RIGHT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: channel loads, and shift/zero strobes that any LR edge suppresses
  always_comb begin
    enter_left_s  = 1'b0;
    enter_right_s = 1'b0;
    active_s      = 1'b0;
    shift_s       = 1'b0;
    zero_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        enter_left_s = lrck_fall_r;
      end
      ST_LEFT: begin
        active_s      = 1'b1;
        enter_left_s  = lrck_fall_r;
        enter_right_s = lrck_rise_r;
      end
      ST_RIGHT: begin
        active_s      = 1'b1;
        enter_left_s  = lrck_fall_r;
        enter_right_s = lrck_rise_r;
      end
      default: begin
        active_s = 1'b0;
      end
    endcase
    if (active_s && bclk_fall_r && !lrck_fall_r && !lrck_rise_r) begin
      if (bit_cnt_r < CNT_FULL) shift_s = 1'b1;
      else                      zero_s  = 1'b1;
    end else begin
      shift_s = 1'b0;
      zero_s  = 1'b0;
    end
  end

  // A pair is accepted only into an empty holding register
  assign accept_s = sample_valid & ~hold_full_r;

  // Word loaded into the shifter at a left start: fresh pair, else underrun policy
  always_comb begin
    left_src_s = tx_l_r;
    if (hold_full_r) begin
      left_src_s = hold_l_r;
    end else begin
`ifdef I2S_TX_UNDERRUN_ZERO_EN
      left_src_s = {DATA_WIDTH{1'b0}};
`else
      left_src_s = tx_l_r;
`endif
    end
  end

  // Holding register handshake and pair transfer into the transmit registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hold_full_r   <= 1'b0;
      hold_l_r      <= {DATA_WIDTH{1'b0}};
      hold_r_r      <= {DATA_WIDTH{1'b0}};
      tx_l_r        <= {DATA_WIDTH{1'b0}};
      tx_r_r        <= {DATA_WIDTH{1'b0}};
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
      if (accept_s) begin
        hold_l_r    <= left_data;
        hold_r_r    <= right_data;
        hold_full_r <= 1'b1;
      end else if (enter_left_s && hold_full_r) begin
        tx_l_r        <= hold_l_r;
        tx_r_r        <= hold_r_r;
        hold_full_r   <= 1'b0;
        frame_start_r <= 1'b1;
      end else if (enter_left_s) begin
        underrun_r <= 1'b1;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
        tx_l_r <= {DATA_WIDTH{1'b0}};
        tx_r_r <= {DATA_WIDTH{1'b0}};
`endif
      end else begin
        hold_full_r <= hold_full_r;
      end
    end
  end

  // Serializer: LR edges reload and hold the line, bclk falls shift MSB first
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      shift_r   <= {DATA_WIDTH{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      dacdat_r  <= 1'b0;
    end else if (enter_left_s) begin
      shift_r   <= left_src_s;
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (enter_right_s) begin
      shift_r   <= tx_r_r;
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (shift_s) begin
      dacdat_r  <= shift_r[DATA_WIDTH-1];
      shift_r   <= {shift_r[DATA_WIDTH-2:0], 1'b0};
      bit_cnt_r <= bit_cnt_r + CNT_W'(1);
    end else if (zero_s) begin
      dacdat_r <= 1'b0;
    end else begin
      dacdat_r <= dacdat_r;
    end
  end

  assign sample_ready = ~hold_full_r;
  assign aud_dacdat   = dacdat_r;
  assign frame_start  = frame_start_r;
  assign underrun     = underrun_r;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx. The bench plays the codec clock master
// (BCLK = 16 CLOCK_50 cycles, 32 BCLKs per half-frame). It samples
// aud_dacdat on every BCLK rise and compares each sample with a frame-level
// model of I2S framing.
`timescale 1ns/1ps
module tb_i2s_dac_tx;
  localparam int DW = 24;
  localparam int HALF_BCLK = 8;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bclk = 1'b1;
  logic lrck = 1'b1;
  logic valid = 1'b0;
  logic [DW-1:0] ldata = '0;
  logic [DW-1:0] rdata = '0;
  logic ready, dacdat, fs, ur;

  int checks = 0;
  int errors = 0;

  // model of the transmitter at frame level
  logic [DW-1:0] m_hold_l, m_hold_r, m_tx_l = '0, m_tx_r = '0, m_word = '0;
  bit m_hold_full = 0;
  bit m_idle = 1;
  logic m_last = 1'b0;
  int exp_fs = 0, exp_ur = 0, obs_fs = 0, obs_ur = 0;

  // codec position and decoded words
  int len_q[$];
  int cur_ch = 1, cur_j = 0, sample_count = 0, half_idx = 0;
  logic [DW-1:0] last_dec_l = '0, last_dec_r = '0;
  int last_ones_l = 0;
  logic last_bit = 1'b0;

  always #10 clk = ~clk;

  i2s_dac_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .CLOCK_50(clk), .reset(reset), .aud_bclk(bclk), .aud_daclrck(lrck),
    .left_data(ldata), .right_data(rdata), .sample_valid(valid),
    .sample_ready(ready), .aud_dacdat(dacdat), .frame_start(fs), .underrun(ur));

  always @(negedge clk) begin
    if (fs === 1'b1) obs_fs++;
    if (ur === 1'b1) obs_ur++;
  end

  function automatic void model_lr_edge(input int ch);
    if (ch == 0) begin
      m_idle = 0;
      if (m_hold_full) begin
        m_tx_l = m_hold_l;
        m_tx_r = m_hold_r;
        m_hold_full = 0;
        exp_fs++;
      end else begin
        exp_ur++;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
        m_tx_l = '0;
        m_tx_r = '0;
`endif
      end
      m_word = m_tx_l;
    end else if (!m_idle) begin
      m_word = m_tx_r;
    end
  endfunction

  function automatic void model_reset();
    m_idle = 1;
    m_hold_full = 0;
    m_tx_l = '0;
    m_tx_r = '0;
    m_last = 1'b0;
  endfunction

  // codec master: LRCK changes on BCLK falls, DAC data sampled on BCLK rises
  initial begin : codec_proc
    int n;
    int ch;
    int ones;
    logic e;
    logic [DW-1:0] dec;
    ch = 1;
    forever begin
      n = (len_q.size() > 0) ? len_q.pop_front() : 32;
      dec = '0;
      ones = 0;
      for (int b = 0; b < n; b++) begin
        @(negedge clk);
        bclk = 1'b0;
        if (b == 0) begin
          lrck = ch[0];
          model_lr_edge(ch);
          half_idx++;
          cur_ch = ch;
        end
        repeat (HALF_BCLK - 1) @(negedge clk);
        @(negedge clk);
        bclk = 1'b1;
        if (b == 0)       e = m_last;
        else if (m_idle)  e = 1'b0;
        else if (b <= DW) e = m_word[DW-b];
        else              e = 1'b0;
        checks++;
        if (dacdat !== e) begin
          errors++;
          $display("FAIL dacdat_bit half=%0d ch=%0d j=%0d: got %b expected %b",
                   half_idx, ch, b, dacdat, e);
        end
        m_last = e;
        last_bit = dacdat;
        if (b >= 1 && b <= DW) dec = {dec[DW-2:0], dacdat};
        if (b >= 1 && dacdat === 1'b1) ones++;
        cur_j = b;
        sample_count++;
        repeat (HALF_BCLK - 1) @(negedge clk);
      end
      if (ch == 0) begin
        last_dec_l = dec;
        last_ones_l = ones;
        checks++;
        if (obs_fs != exp_fs || obs_ur != exp_ur) begin
          errors++;
          $display("FAIL pulse_counts: got fs=%0d ur=%0d expected fs=%0d ur=%0d",
                   obs_fs, obs_ur, exp_fs, exp_ur);
        end
      end else begin
        last_dec_r = dec;
      end
      ch = 1 - ch;
    end
  end

  task automatic wait_sample(input int ch, input int j);
    int last;
    bit hit;
    last = sample_count;
    hit = 0;
    for (int i = 0; i < BUDGET && !hit; i++) begin
      @(negedge clk);
      if (sample_count != last) begin
        last = sample_count;
        if (cur_ch == ch && cur_j == j) hit = 1;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_sample_timeout: got no ch=%0d j=%0d expected within %0d cycles",
               ch, j, BUDGET);
    end
  endtask

  task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r,
                           input bit expect_wait);
    int start_half;
    bit got;
    start_half = half_idx;
    @(negedge clk);
    valid = 1'b1;
    ldata = l;
    rdata = r;
    got = 0;
    for (int i = 0; i < BUDGET && !got; i++) begin
      if (ready === 1'b1) begin
        @(posedge clk);
        got = 1;
        checks++;
        if (m_hold_full) begin
          errors++;
          $display("FAIL accept_while_full: got accept expected wait (L=%h)", l);
        end
        m_hold_l = l;
        m_hold_r = r;
        m_hold_full = 1;
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_after_accept: got %b expected 0", ready);
        end
        if (expect_wait) begin
          checks++;
          if (half_idx == start_half) begin
            errors++;
            $display("FAIL early_accept: got half %0d expected after %0d", half_idx, start_half);
          end
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      valid = 1'b0;
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got no accept expected within %0d cycles", BUDGET);
    end
  endtask

  task automatic check_word(input string name, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (dacdat !== 1'b0 || ready !== 1'b1 || fs !== 1'b0 || ur !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got dat=%b rdy=%b fs=%b ur=%b expected 0 1 0 0",
               dacdat, ready, fs, ur);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_frame();
    send_pair(24'hA5A5A5, 24'h3C3C3C, 0);
    wait_sample(0, 8);
    wait_sample(1, 0);
    check_word("first_left", last_dec_l, 24'hA5A5A5);
    checks++;
    if (obs_fs != 1) begin
      errors++;
      $display("FAIL first_frame_start: got %0d expected 1", obs_fs);
    end
    wait_sample(0, 0);
    check_word("first_right", last_dec_r, 24'h3C3C3C);
  endtask

  task automatic test_four_frames();
    int ur0;
    logic [DW-1:0] exp_l;
    ur0 = obs_ur;
    for (int i = 1; i <= 4; i++) begin
      wait_sample(0, 8);
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL ready_per_frame: got %b expected 1", ready);
      end
      send_pair(DW'(i), DW'($urandom()), 0);
      wait_sample(1, 0);
      exp_l = (i == 1) ? 24'hA5A5A5 : DW'(i - 1);
      check_word("seq_left", last_dec_l, exp_l);
    end
    checks++;
    if (obs_ur != ur0) begin
      errors++;
      $display("FAIL no_underrun: got %0d expected %0d", obs_ur, ur0);
    end
  endtask

  task automatic test_underrun();
    int ur0;
    logic [DW-1:0] exp_l;
    wait_sample(0, 8);
    send_pair(24'h123456, DW'($urandom()), 0);
    wait_sample(1, 0);
    check_word("seq_left_4", last_dec_l, 24'd4);
    ur0 = obs_ur;
    wait_sample(0, 8);
    wait_sample(1, 0);
    check_word("pre_underrun_left", last_dec_l, 24'h123456);
    wait_sample(0, 8);
    wait_sample(1, 0);
`ifdef I2S_TX_UNDERRUN_ZERO_EN
    exp_l = 24'h000000;
`else
    exp_l = 24'h123456;
`endif
    check_word("underrun_left", last_dec_l, exp_l);
    checks++;
    if (obs_ur != ur0 + 1) begin
      errors++;
      $display("FAIL underrun_pulse: got %0d expected %0d", obs_ur - ur0, 1);
    end
  endtask

  task automatic test_hold_busy();
    logic [DW-1:0] p1, p2;
    p1 = DW'($urandom());
    p2 = DW'($urandom());
    wait_sample(0, 8);
    send_pair(p1, DW'($urandom()), 0);
    send_pair(p2, DW'($urandom()), 1);
    wait_sample(1, 0);
    check_word("busy_first", last_dec_l, p1);
    wait_sample(0, 8);
    wait_sample(1, 0);
    check_word("busy_second", last_dec_l, p2);
  endtask

  task automatic test_short_frame();
    logic [DW-1:0] r;
    r = DW'($urandom());
    wait_sample(0, 8);
    send_pair(24'hFFFFFF, r, 0);
    wait_sample(1, 8);
    len_q.push_back(16);
    wait_sample(1, 0);
    checks++;
    if (last_ones_l + int'(last_bit) != 16) begin
      errors++;
      $display("FAIL short_ones: got %0d expected 16", last_ones_l + int'(last_bit));
    end
    wait_sample(0, 0);
    check_word("short_right", last_dec_r, r);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] q;
    q = DW'($urandom());
    wait_sample(0, 10);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (dacdat !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got dat=%b rdy=%b expected 0 1", dacdat, ready);
    end
    reset = 1'b0;
    wait_sample(1, 8);
    checks++;
    if (dacdat !== 1'b0) begin
      errors++;
      $display("FAIL idle_right: got %b expected 0", dacdat);
    end
    send_pair(q, DW'($urandom()), 0);
    wait_sample(0, 8);
    wait_sample(1, 0);
    check_word("resume_left", last_dec_l, q);
  endtask

  task automatic test_random();
    int mode;
    for (int f = 0; f < 10; f++) begin
      wait_sample(0, 8);
      mode = $urandom_range(0, 9);
      if (mode < 2) begin
        // skip this frame to provoke an underrun
      end else if (mode < 4) begin
        send_pair(DW'($urandom()), DW'($urandom()), 0);
        send_pair(DW'($urandom()), DW'($urandom()), 0);
      end else begin
        send_pair(DW'($urandom()), DW'($urandom()), 0);
      end
    end
    wait_sample(0, 8);
    wait_sample(0, 8);
    wait_sample(1, 0);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_four_frames();
    test_underrun();
    test_hold_busy();
    test_short_frame();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
